mem_bist_ctrl: RTL
==================

// Module: mem_bist_ctrl
// PURPOSE
//   Initiator-side controller for the single-port mem (clk/rd/wr/addr/wdata/rdata).
//   On start, writes a data pattern to every location and reads it back for comparison.
//   It then repeats the write/read pass with the inverted pattern and reports pass/fail.
//   It sits between system control and mem's port and replaces manual bench-driven accesses.
// PARAMETERS
//   DATA_WIDTH  32            mem data width
//   ADDR_WIDTH  8             mem address width; depth = 2**ADDR_WIDTH
//   PATTERN     32'hcafebabe  base data pattern (DATA_WIDTH bits)
//   FCNT_W      16            width of the failure counter
// PORTS
//   clk        in   1           clock, all logic on posedge
//   rst_n      in   1           synchronous reset, active-low
//   start      in   1           start request, sampled in IDLE only
//   busy       out  1           high from the cycle after start until DONE
//   done       out  1           high in DONE, held until next start or reset
//   pass       out  1           done && fail_cnt==0
//   fail_cnt   out  FCNT_W      count of mismatching reads, saturating
//   fail_addr  out  ADDR_WIDTH  address of first mismatch; 0 if none
//   mem_rd     out  1           to mem rd
//   mem_wr     out  1           to mem wr
//   mem_addr   out  ADDR_WIDTH  to mem addr
//   mem_wdata  out  DATA_WIDTH  to mem wdata
//   mem_rdata  in   DATA_WIDTH  from mem rdata; valid 1 cycle after mem_rd is sampled
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): all outputs 0 and state=IDLE. Reset overrides any state,
//     including mid-pass. No partial access survives reset.
//   Expected data: E0(a) = PATTERN ^ zext(a), E1(a) = ~E0(a); all arithmetic is DATA_WIDTH wide.
//   States: IDLE -> WR0 -> RD0 -> DR0 -> WR1 -> RD1 -> DR1 -> DONE.
//   IDLE: mem_rd=mem_wr=0. If start=1, go to WR0 and clear done, pass, fail_cnt and fail_addr.
//   WR0/WR1: one write per cycle; mem_wr=1, mem_wdata=E0/E1(mem_addr).
//     Address runs 0 up to 2**ADDR_WIDTH-1. At the last address, go to RD0/RD1 with addr wrapped to 0.
//   RD0/RD1: one read per cycle; mem_rd=1, address runs 0 up to max. At the last address, go to DR0/DR1.
//   DR0/DR1: one drain cycle; mem_rd=0; compares the final read. DR0 -> WR1 (addr 0); DR1 -> DONE.
//   Compare pipeline: the read issued in cycle n is compared in cycle n+1 against
//     E(addr delayed 1). Use a registered valid and address; no bubbles.
//   Mismatch: fail_cnt += 1, saturating at 2**FCNT_W-1. fail_addr latches on the first mismatch only.
//   mem_rd and mem_wr are never high in the same cycle. Both are 0 in IDLE and DONE.
//   Duration: start accepted at edge k -> done=1 after 4*2**ADDR_WIDTH+2 busy cycles (1026 for 8).
//   DONE: busy=0, done=1, pass valid. A start here re-enters WR0 and clears stats as in IDLE.
//   start while busy is ignored, with no effect on state or counters.
// TESTING
//   1 Fault-free mem, start pulse -> busy 1026 cycles, then done=1, pass=1, fail_cnt=0, fail_addr=0.
//   2 Access count on run 1 -> exactly 512 mem_wr cycles and 512 mem_rd cycles.
//     Never both high. Addresses walk 0..255 in each pass.
//   3 Mem model with bit0 stuck-at-0 at addr 8'h15 -> E0=32'hcafebaab fails, E1 passes.
//     Result: fail_cnt=1, fail_addr=8'h15, pass=0.
//   4 Stuck-at faults at addr 8'h03 and 8'h80 -> fail_addr=8'h03, fail_cnt=2, pass=0.
//   5 rst_n=0 for 1 cycle mid-RD0 (addr 8'h40) -> next edge all outputs 0, state IDLE.
//     A new start then gives a full clean run and pass=1.
//   6 start re-asserted during WR1 is ignored (duration still 1026).
//     start in DONE after run 3 -> stats clear; fault-free model gives pass=1.

Source files
------------

// File: rtl/mem_bist_ctrl.sv
// March-style BIST initiator for a single-port memory: pattern write/read pass,
// then the same with inverted data, reporting mismatch count and first failing address.
module mem_bist_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 32'hcafebabe,
    parameter int                    FCNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [FCNT_W-1:0]     fail_cnt,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [2:0]            dbg_state
);

    // Memory port: mem_wr/mem_rd are single-cycle strobes with no backpressure;
    // mem_rdata answers a read one cycle after mem_rd was sampled.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        RD0  = 3'd2,
        DR0  = 3'd3,
        WR1  = 3'd4,
        RD1  = 3'd5,
        DR1  = 3'd6,
        DONE = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  addr_last;
    logic                  clear_stats;
    logic                  rd_vld_q;
    logic                  rd_inv_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  mismatch;

    function automatic logic [DATA_WIDTH-1:0] exp_data(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic inv);
        logic [DATA_WIDTH-1:0] e;
        e = PATTERN ^ DATA_WIDTH'(a);
        return inv ? ~e : e;
    endfunction

    assign addr_last = &addr_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_wdata   = '0;
        clear_stats = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = WR0;
                    addr_d      = '0;
                    clear_stats = 1'b1;
                end
            end
            WR0, WR1: begin
                mem_wr    = 1'b1;
                mem_wdata = exp_data(addr_q, state_q == WR1);
                addr_d    = addr_q + 1'b1;
                if (addr_last) state_d = (state_q == WR0) ? RD0 : RD1;
            end
            RD0, RD1: begin
                mem_rd = 1'b1;
                addr_d = addr_q + 1'b1;
                if (addr_last) state_d = (state_q == RD0) ? DR0 : DR1;
            end
            DR0: begin
                state_d = WR1;
                addr_d  = '0;
            end
            DR1: begin
                state_d = DONE;
                addr_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // The read issued last cycle is checked now against its delayed address and phase.
    assign mismatch = rd_vld_q && (mem_rdata != exp_data(rd_addr_q, rd_inv_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_inv_q  <= 1'b0;
            rd_addr_q <= '0;
            fail_cnt  <= '0;
            fail_addr <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_vld_q  <= mem_rd;
            rd_inv_q  <= (state_q == RD1);
            rd_addr_q <= addr_q;
            if (clear_stats) begin
                fail_cnt  <= '0;
                fail_addr <= '0;
            end else if (mismatch) begin
                if (fail_cnt == '0) fail_addr <= rd_addr_q;
                if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign pass      = done && (fail_cnt == '0);
    assign dbg_state = state_q;

endmodule
